// File: rtl/wb_sysram_pkg.sv
// rtl/wb_sysram_pkg.sv - shared state encodings, window constants and lane helper for the system RAM slave
package wb_sysram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_HOLD = 3'd3,
    ST_WIPE = 3'd4
  } state_t;

  localparam logic [15:0] SYSRAM_BASE = 16'o177600;
  localparam logic [15:0] SYSRAM_MASK = 16'o177700;

  // Zero every byte lane whose select bit is clear.
  function automatic logic [15:0] lane_mask(input logic [15:0] data, input logic [1:0] sel);
    return {sel[1] ? data[15:8] : 8'h00, sel[0] ? data[7:0] : 8'h00};
  endfunction

endpackage

// File: rtl/wb_sysram_array.sv
// rtl/wb_sysram_array.sv - 2**ADR_W x 16 storage with per-lane write enable and async read
module wb_sysram_array #(
  parameter int unsigned ADR_W = 5
) (
  input  logic             clk,
  input  logic [1:0]       wr_en,
  input  logic [ADR_W-1:0] wr_adr,
  input  logic [15:0]      wr_dat,
  input  logic [ADR_W-1:0] rd_adr,
  output logic [15:0]      rd_dat
);

  logic [15:0] mem [2**ADR_W];

  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[wr_adr][7:0]  <= wr_dat[7:0];
    if (wr_en[1]) mem[wr_adr][15:8] <= wr_dat[15:8];
  end

  assign rd_dat = mem[rd_adr];

endmodule

// File: rtl/wb_sysram_slave.sv
// rtl/wb_sysram_slave.sv - Wishbone system RAM responder with wait states, abort on CYC drop and INIT wipe
module wb_sysram_slave
  import wb_sysram_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned ADR_W    = 5,
  parameter logic [15:0] CLR_VAL  = 16'o000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        init_i,
  output logic        busy_o
);

  localparam bit               ZERO_WAIT = (WAIT_CYC == 0);
  localparam logic [2:0]       CNT_INIT  = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);
  localparam logic [ADR_W-1:0] PTR_LAST  = '1;

  state_t           state;
  logic [2:0]       cnt;
  logic [ADR_W-1:0] ptr;
  logic             init_q;
  logic             pend;
  logic [ADR_W-1:0] lat_adr;
  logic             lat_we;
  logic [1:0]       lat_sel;
  logic [15:0]      lat_dat;

  logic             req;
  logic             init_edge;
  logic             start;
  logic             go_ack;
  logic             in_idle;
  logic [ADR_W-1:0] acc_adr;
  logic             acc_we;
  logic [1:0]       acc_sel;
  logic [15:0]      acc_dat;
  logic [1:0]       wr_en;
  logic [ADR_W-1:0] wr_adr;
  logic [15:0]      wr_dat;
  logic [15:0]      rd_dat;
  logic [15:0]      rd_masked;
  logic             unused_in_window;

  assign req       = wb_cyc_i & wb_stb_i;
  assign init_edge = init_i & ~init_q;
  assign in_idle   = (state == ST_IDLE);
  assign start     = in_idle & req & ~init_edge & ~pend;
  assign go_ack    = (start & ZERO_WAIT) | ((state == ST_WAIT) & wb_cyc_i & (cnt == 3'd0));

  // A zero-wait access commits from IDLE before the latches are loaded, so use the live bus there.
  assign acc_adr = in_idle ? wb_adr_i[ADR_W:1] : lat_adr;
  assign acc_we  = in_idle ? wb_we_i  : lat_we;
  assign acc_sel = in_idle ? wb_sel_i : lat_sel;
  assign acc_dat = in_idle ? wb_dat_i : lat_dat;

  always_comb begin
    wr_en  = 2'b00;
    wr_adr = acc_adr;
    wr_dat = acc_dat;
    if (state == ST_WIPE) begin
      wr_en  = 2'b11;
      wr_adr = ptr;
      wr_dat = CLR_VAL;
    end else if (go_ack && acc_we) begin
      wr_en = acc_sel;
    end
  end

  assign rd_masked = lane_mask(rd_dat, acc_sel);

  // Window decode is done upstream; the check is kept only for reference.
  assign unused_in_window = ((wb_adr_i & SYSRAM_MASK) == SYSRAM_BASE) ^ wb_adr_i[0];

  wb_sysram_array #(.ADR_W(ADR_W)) u_array (
    .clk    (wb_clk_i),
    .wr_en  (wr_en),
    .wr_adr (wr_adr),
    .wr_dat (wr_dat),
    .rd_adr (acc_adr),
    .rd_dat (rd_dat)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      ptr      <= '0;
      init_q   <= 1'b0;
      pend     <= 1'b0;
      lat_adr  <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= 2'b00;
      lat_dat  <= 16'h0000;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 16'h0000;
      busy_o   <= 1'b0;
    end else begin
      init_q   <= init_i;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 16'h0000;
      if (init_edge && (state == ST_WAIT || state == ST_ACK || state == ST_HOLD))
        pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (init_edge || pend) begin
            state  <= ST_WIPE;
            ptr    <= '0;
            busy_o <= 1'b1;
            pend   <= 1'b0;
          end else if (req) begin
            lat_adr <= wb_adr_i[ADR_W:1];
            lat_we  <= wb_we_i;
            lat_sel <= wb_sel_i;
            lat_dat <= wb_dat_i;
            if (ZERO_WAIT) begin
              state    <= ST_ACK;
              wb_ack_o <= 1'b1;
              wb_dat_o <= acc_we ? 16'h0000 : rd_masked;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else if (cnt == 3'd0) begin
            state    <= ST_ACK;
            wb_ack_o <= 1'b1;
            wb_dat_o <= acc_we ? 16'h0000 : rd_masked;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_ACK: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!wb_stb_i || !wb_cyc_i) state <= ST_IDLE;
        end
        ST_WIPE: begin
          if (init_edge) begin
            ptr <= '0;
          end else if (ptr == PTR_LAST) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sysram_slave.sv
// tb/tb_wb_sysram_slave.sv - directed-vector bench for wb_sysram_slave (WAIT_CYC=1 and WAIT_CYC=3 instances)
module tb_wb_sysram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] adr = '0;
  logic [15:0] dat_i = '0;
  logic        cyc = 1'b0;
  logic        stb1 = 1'b0;
  logic        stb3 = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic        init = 1'b0;
  logic [15:0] dat1, dat3;
  logic        ack1, ack3, busy1, busy3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_sysram_slave #(.WAIT_CYC(1)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat1),
    .wb_cyc_i(cyc), .wb_stb_i(stb1), .wb_we_i(we), .wb_sel_i(sel), .wb_ack_o(ack1),
    .init_i(init), .busy_o(busy1)
  );

  wb_sysram_slave #(.WAIT_CYC(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat3),
    .wb_cyc_i(cyc), .wb_stb_i(stb3), .wb_we_i(we), .wb_sel_i(sel), .wb_ack_o(ack3),
    .init_i(init), .busy_o(busy3)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic xfer(input int which, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] s, input bit init_hold, output logic [15:0] rd,
                      output int lat, output int acks, output logic busy_ack);
    @(negedge clk);
    adr = a; dat_i = d; we = wr; sel = s; cyc = 1'b1;
    if (which == 3) stb3 = 1'b1; else stb1 = 1'b1;
    lat = -1; acks = 0; rd = '0; busy_ack = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((which == 3) ? ack3 : ack1) begin
        lat = i;
        rd = (which == 3) ? dat3 : dat1;
        busy_ack = (which == 3) ? busy3 : busy1;
        break;
      end
    end
    if (lat > 0) begin
      acks = 1;
      if (init_hold) begin
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        acks += int'((which == 3) ? ack3 : ack1);
      end
      cyc = 1'b0; stb1 = 1'b0; stb3 = 1'b0; we = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        acks += int'((which == 3) ? ack3 : ack1);
      end
    end else begin
      cyc = 1'b0; stb1 = 1'b0; stb3 = 1'b0; we = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] rdv;
    int lat, acks, cnt;
    logic bz;

    // reset state
    repeat (3) @(negedge clk);
    check_vec("rst_ack", ack1, 0);
    check_vec("rst_dat", dat1, 0);
    check_vec("rst_busy", busy1, 0);
    check_vec("rst_ack3", ack3, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: word write / read, latency and ACK width
    xfer(1, 1, 16'o177602, 16'o123456, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t1_wr_lat", lat, 2);
    check_vec("t1_wr_acks", acks, 1);
    xfer(1, 0, 16'o177602, 16'o0, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t1_rd_dat", rdv, 16'o123456);
    check_vec("t1_rd_lat", lat, 2);
    check_vec("t1_dat_after", dat1, 0);

    // 2: byte lanes
    xfer(1, 1, 16'o177604, 16'o052525, 2'b11, 0, rdv, lat, acks, bz);
    xfer(1, 1, 16'o177604, 16'o000377, 2'b01, 0, rdv, lat, acks, bz);
    xfer(1, 0, 16'o177604, 16'o0, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t2_lo_write", rdv, 16'o052777);
    xfer(1, 0, 16'o177604, 16'o0, 2'b10, 0, rdv, lat, acks, bz);
    check_vec("t2_hi_read", rdv, 16'o052400);
    xfer(1, 0, 16'o177604, 16'o0, 2'b01, 0, rdv, lat, acks, bz);
    check_vec("t2_lo_read", rdv, 16'o000377);
    xfer(1, 1, 16'o177604, 16'o000000, 2'b00, 0, rdv, lat, acks, bz);
    check_vec("t2_sel00_acks", acks, 1);
    xfer(1, 0, 16'o177604, 16'o0, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t2_sel00_keep", rdv, 16'o052777);

    // 3: abort in WAIT on the WAIT_CYC=3 instance
    xfer(3, 1, 16'o177602, 16'o123456, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t3_wr_lat", lat, 4);
    @(negedge clk);
    adr = 16'o177602; dat_i = 16'o000777; we = 1'b1; sel = 2'b11; cyc = 1'b1; stb3 = 1'b1;
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb3 = 1'b0; we = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(ack3);
    end
    check_vec("t3_abort_noack", cnt, 0);
    xfer(3, 0, 16'o177602, 16'o0, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t3_old_data", rdv, 16'o123456);

    // 4: wipe length and contents
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check_vec("t4_busy_cycles", cnt, 32);
    for (int i = 0; i < 32; i++) begin
      xfer(1, 0, 16'o177600 + 16'(2 * i), 16'o0, 2'b11, 0, rdv, lat, acks, bz);
      check_vec($sformatf("t4_wiped_w%0d", i), rdv, 0);
    end
    xfer(1, 1, 16'o177602, 16'o111111, 2'b11, 0, rdv, lat, acks, bz);
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    xfer(1, 0, 16'o177602, 16'o0, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t4_midwipe_busy", bz, 0);
    check_vec("t4_midwipe_lat", lat, 33);
    check_vec("t4_midwipe_dat", rdv, 0);
    check_vec("t4_midwipe_acks", acks, 1);

    // 5: INIT during HOLD
    repeat (40) @(negedge clk);
    xfer(1, 1, 16'o177606, 16'o054321, 2'b11, 1, rdv, lat, acks, bz);
    check_vec("t5_acks", acks, 1);
    check_vec("t5_busy_after", busy1, 1);
    cnt = 0;
    while (busy1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    xfer(1, 0, 16'o177606, 16'o0, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t5_cleared", rdv, 0);

    // 6: async reset during WAIT, during ACK and during wipe
    @(negedge clk);
    adr = 16'o177610; dat_i = 16'o000123; we = 1'b1; sel = 2'b11; cyc = 1'b1; stb3 = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_vec("t6_wait_ack", ack3, 0);
    check_vec("t6_wait_busy", busy3, 0);
    cyc = 1'b0; stb3 = 1'b0; we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    xfer(1, 1, 16'o177610, 16'o070707, 2'b11, 0, rdv, lat, acks, bz);
    @(negedge clk);
    adr = 16'o177610; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb1 = 1'b1;
    repeat (2) @(negedge clk);
    check_vec("t6_pre_ack", ack1, 1);
    check_vec("t6_pre_dat", dat1, 16'o070707);
    #1 rst_n = 1'b0;
    #1;
    check_vec("t6_ack_async", ack1, 0);
    check_vec("t6_dat_async", dat1, 0);
    cyc = 1'b0; stb1 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("t6_wipe_busy", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    check_vec("t6_busy_async", busy1, 0);
    @(negedge clk); rst_n = 1'b1;
    xfer(1, 1, 16'o177612, 16'o135246, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t6_post_wr_lat", lat, 2);
    xfer(1, 0, 16'o177612, 16'o0, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t6_post_rd", rdv, 16'o135246);
    xfer(3, 1, 16'o177614, 16'o000042, 2'b11, 0, rdv, lat, acks, bz);
    check_vec("t6_post_lat3", lat, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
